// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer. It performs 32 shift-add or restoring
// shift-subtract steps on a borrowed ALU and holds the HI/LO result registers.
module mdu_sequencer #(
   parameter logic [5:0] FUNC_ADD = 6'h20,
   parameter logic [5:0] FUNC_SUB = 6'h22
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic [31:0] alu_opa,
   output logic [31:0] alu_opb,
   output logic [5:0]  alu_func,
   input  logic [31:0] alu_res,
   input  logic        alu_cout,
   output logic        busy,
   output logic        done,
   output logic        div_zero,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_POST} state_t;

   state_t      r_state;
   logic [4:0]  r_count;
   logic        r_is_div;
   logic        r_signed;
   logic        r_sign_a;
   logic        r_sign_b;
   logic [31:0] r_acc;
   logic [31:0] r_lo_w;
   logic [31:0] r_operand;
   logic [31:0] r_raw_a;
   logic        r_busy;
   logic        r_done;
   logic        r_div_zero;
   logic [31:0] r_hi;
   logic [31:0] r_lo;

   logic        w_signed_req;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_div_r;
   logic        w_div_ok;
   logic [63:0] w_prod_neg;
   logic [31:0] w_q_neg;
   logic [31:0] w_rem_neg;

   // op[0] set means unsigned; magnitudes of 0x80000000 stay 0x80000000
   assign w_signed_req = ~op[0];
   assign w_abs_a      = (w_signed_req && opa[31]) ? (~opa + 32'd1) : opa;
   assign w_abs_b      = (w_signed_req && opb[31]) ? (~opb + 32'd1) : opb;

   assign w_div_r    = {r_acc[30:0], r_lo_w[31]};
   assign w_div_ok   = r_acc[31] | alu_cout;
   assign w_prod_neg = ~{r_acc, r_lo_w} + 64'd1;
   assign w_q_neg    = ~r_lo_w + 32'd1;
   assign w_rem_neg  = ~r_acc + 32'd1;

   assign alu_opa  = (r_state == S_ITER) ? (r_is_div ? w_div_r : r_acc) : 32'd0;
   assign alu_opb  = (r_state == S_ITER) ? r_operand : 32'd0;
   assign alu_func = (r_state == S_ITER && r_is_div) ? FUNC_SUB : FUNC_ADD;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_count    <= 5'd0;
         r_is_div   <= 1'b0;
         r_signed   <= 1'b0;
         r_sign_a   <= 1'b0;
         r_sign_b   <= 1'b0;
         r_acc      <= 32'd0;
         r_lo_w     <= 32'd0;
         r_operand  <= 32'd0;
         r_raw_a    <= 32'd0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_div_zero <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_is_div   <= op[1];
                  r_signed   <= w_signed_req;
                  r_sign_a   <= opa[31];
                  r_sign_b   <= opb[31];
                  r_raw_a    <= opa;
                  r_acc      <= 32'd0;
                  r_lo_w     <= op[1] ? w_abs_a : w_abs_b;
                  r_operand  <= op[1] ? w_abs_b : w_abs_a;
                  r_div_zero <= op[1] && (opb == 32'd0);
                  r_count    <= 5'd0;
                  r_busy     <= 1'b1;
                  r_state    <= S_ITER;
               end
            end
            S_ITER: begin
               if (r_is_div) begin
                  r_acc  <= w_div_ok ? alu_res : w_div_r;
                  r_lo_w <= {r_lo_w[30:0], w_div_ok};
               end else if (r_lo_w[0]) begin
                  r_acc  <= {alu_cout, alu_res[31:1]};
                  r_lo_w <= {alu_res[0], r_lo_w[31:1]};
               end else begin
                  r_acc  <= {1'b0, r_acc[31:1]};
                  r_lo_w <= {r_acc[0], r_lo_w[31:1]};
               end
               r_count <= r_count + 5'd1;
               if (r_count == 5'd31) begin
                  r_state <= S_POST;
               end
            end
            S_POST: begin
               if (r_div_zero) begin
                  r_hi <= r_raw_a;
                  r_lo <= 32'hFFFF_FFFF;
               end else if (r_is_div) begin
                  r_lo <= (r_signed && (r_sign_a ^ r_sign_b)) ? w_q_neg : r_lo_w;
                  r_hi <= (r_signed && r_sign_a) ? w_rem_neg : r_acc;
               end else if (r_signed && (r_sign_a ^ r_sign_b)) begin
                  r_hi <= w_prod_neg[63:32];
                  r_lo <= w_prod_neg[31:0];
               end else begin
                  r_hi <= r_acc;
                  r_lo <= r_lo_w;
               end
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign div_zero = r_div_zero;
   assign hi       = r_hi;
   assign lo       = r_lo;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer: supplies the shared ALU and compares
// results against 64-bit arithmetic reference results.
module tb_mdu_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] opa = 32'd0;
   logic [31:0] opb = 32'd0;
   logic [31:0] alu_opa;
   logic [31:0] alu_opb;
   logic [5:0]  alu_func;
   logic [31:0] alu_res;
   logic        alu_cout;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mdu_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
      .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_func(alu_func),
      .alu_res(alu_res), .alu_cout(alu_cout),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   // Shared ALU: add, or subtract as opa + ~opb + 1 with its raw carry-out
   always_comb begin
      logic [32:0] sum;
      sum = 33'd0;
      if (alu_func == 6'h22) sum = {1'b0, alu_opa} + {1'b0, ~alu_opb} + 33'd1;
      else                   sum = {1'b0, alu_opa} + {1'b0, alu_opb};
      alu_res  = sum[31:0];
      alu_cout = sum[32];
   end

   function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l, output logic dz);
      longint sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      dz = 1'b0;
      h = 32'd0;
      l = 32'd0;
      case (o)
         2'd0: begin sp = sa * sb; up = sp; h = up[63:32]; l = up[31:0]; end
         2'd1: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; end
         default: begin
            if (b == 32'd0) begin
               h = a; l = 32'hFFFF_FFFF; dz = 1'b1;
            end else if (o == 2'd2) begin
               sq = sa / sb; sr = sa % sb;
               up = sq; l = up[31:0];
               up = sr; h = up[31:0];
            end else begin
               l = a / b; h = a % b;
            end
         end
      endcase
   endfunction

   // Launches one op from IDLE and tracks it; optionally pokes start at
   // pulse_k or asserts reset at rst_k (k = edges after the accepting edge).
   task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int pulse_k, input int rst_k,
                        output int lat, output logic [31:0] h, output logic [31:0] l,
                        output logic dz, output bit busy_ok, output bit func_ok, output bit aborted);
      logic [5:0] exp_func;
      exp_func = o[1] ? 6'h22 : 6'h20;
      lat = -1; h = 32'd0; l = 32'd0; dz = 1'b0;
      busy_ok = 1'b1; func_ok = 1'b1; aborted = 1'b0;
      op = o; opa = a; opb = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); opa = $urandom; opb = $urandom;
      for (int k = 0; k < 100; k++) begin
         if (busy !== (k < 33)) busy_ok = 1'b0;
         if (done === 1'b1) begin
            lat = k; h = hi; l = lo; dz = div_zero;
            break;
         end
         if (k <= 31 && alu_func !== exp_func) func_ok = 1'b0;
         if (k == pulse_k) begin
            start = 1'b1; op = 2'($urandom); opa = $urandom; opb = $urandom;
         end
         if (k == pulse_k + 1) start = 1'b0;
         if (k == rst_k) begin
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0; aborted = 1'b1;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({busy, done, div_zero} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b dz=%b hi=%h lo=%h, required all zero", busy, done, div_zero, hi, lo);
      end
      n_checks++;
      if (alu_func !== 6'h20 || alu_opa !== 32'd0 || alu_opb !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_alu: func=%h opa=%h opb=%h, required 20/0/0", alu_func, alu_opa, alu_opb);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [1:0]  vo [9] = '{2'd1, 2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd3, 2'd1, 2'd2};
      logic [31:0] va [9] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFFF,
                              32'hFFFFFFFF, 32'd100, 32'd2, 32'h80000000};
      logic [31:0] vb [9] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd2, 32'h10,
                              32'h80000001, 32'd0, 32'd3, 32'hFFFFFFFF};
      logic [31:0] eh [9] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000, 32'hFFFFFFFF, 32'hF,
                              32'h7FFFFFFE, 32'h64, 32'd0, 32'd0};
      logic [31:0] el [9] = '{32'h1, 32'hFFFFFFEB, 32'd0, 32'hFFFFFFFD, 32'h0FFFFFFF,
                              32'd1, 32'hFFFFFFFF, 32'd6, 32'h80000000};
      logic        ez [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      int lat; logic [31:0] h, l; logic dz; bit bok, fok, ab;
      for (int i = 0; i < 9; i++) begin
         do_op(vo[i], va[i], vb[i], -1, -1, lat, h, l, dz, bok, fok, ab);
         $display("directed %0d: op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b lat=%0d", i, vo[i], va[i], vb[i], h, l, dz, lat);
         n_checks++;
         if (lat != 33) begin n_fail++; $display("FAIL dir%0d_latency: got %0d, required 33", i, lat); end
         n_checks++;
         if (h !== eh[i] || l !== el[i]) begin
            n_fail++; $display("FAIL dir%0d_result: hi=%h lo=%h, required hi=%h lo=%h", i, h, l, eh[i], el[i]);
         end
         n_checks++;
         if (dz !== ez[i]) begin n_fail++; $display("FAIL dir%0d_div_zero: got %b, required %b", i, dz, ez[i]); end
         n_checks++;
         if (!bok || !fok) begin n_fail++; $display("FAIL dir%0d_busy_func: busy_ok=%b func_ok=%b, required 1/1", i, bok, fok); end
      end
   endtask

   task automatic test_random();
      logic [31:0] specials [4] = '{32'd0, 32'h80000000, 32'hFFFFFFFF, 32'd1};
      int lat; logic [31:0] h, l, rh, rl, a, b; logic dz, rz; bit bok, fok, ab; logic [1:0] o;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom);
         a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
         b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : ($urandom >> $urandom_range(0, 31));
         ref_model(o, a, b, rh, rl, rz);
         do_op(o, a, b, -1, -1, lat, h, l, dz, bok, fok, ab);
         $display("random %0d: op=%0d a=%h b=%h -> hi=%h lo=%h dz=%b", i, o, a, b, h, l, dz);
         n_checks++;
         if (lat != 33 || h !== rh || l !== rl || dz !== rz || !bok || !fok) begin
            n_fail++;
            $display("FAIL rand%0d: lat=%0d hi=%h lo=%h dz=%b bok=%b fok=%b, required lat=33 hi=%h lo=%h dz=%b", i, lat, h, l, dz, bok, fok, rh, rl, rz);
         end
      end
   endtask

   task automatic test_start_ignored();
      int lat; logic [31:0] h, l; logic dz; bit bok, fok, ab;
      do_op(2'd3, 32'd1000, 32'd7, 5, -1, lat, h, l, dz, bok, fok, ab);
      $display("start_ignored: hi=%h lo=%h lat=%0d", h, l, lat);
      n_checks++;
      if (lat != 33 || h !== 32'd6 || l !== 32'd142 || !bok) begin
         n_fail++; $display("FAIL start_ignored: lat=%0d hi=%h lo=%h bok=%b, required 33/6/142/1", lat, h, l, bok);
      end
      // nothing queued: no second done may follow
      n_checks++;
      lat = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) lat = 1;
      end
      if (lat != 0) begin n_fail++; $display("FAIL start_queued: activity after done, required none"); end
   endtask

   task automatic test_abort_reset();
      int lat; logic [31:0] h, l; logic dz; bit bok, fok, ab, seen;
      do_op(2'd1, 32'h12345678, 32'h9ABCDEF0, -1, 10, lat, h, l, dz, bok, fok, ab);
      $display("abort: aborted=%b busy=%b done=%b hi=%h lo=%h", ab, busy, done, hi, lo);
      n_checks++;
      if (!ab || busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         n_fail++; $display("FAIL abort_state: busy=%b done=%b hi=%h lo=%h, required 0/0/0/0", busy, done, hi, lo);
      end
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen = 1'b1;
      end
      n_checks++;
      if (seen) begin n_fail++; $display("FAIL abort_done: done seen after reset, required none"); end
      do_op(2'd1, 32'd5, 32'd5, -1, -1, lat, h, l, dz, bok, fok, ab);
      $display("after_abort MULTU 5x5: hi=%h lo=%h lat=%0d", h, l, lat);
      n_checks++;
      if (lat != 33 || h !== 32'd0 || l !== 32'd25) begin
         n_fail++; $display("FAIL after_abort: lat=%0d hi=%h lo=%h, required 33/0/25", lat, h, l);
      end
   endtask

   task automatic test_back_to_back();
      int lat1, lat2; logic [31:0] rh, rl; logic rz;
      lat1 = -1; lat2 = -1;
      op = 2'd0; opa = 32'hFFFFFFF0; opb = 32'd9; start = 1'b1;
      @(posedge clk); #1;
      op = 2'd2; opa = 32'hFFFFFF9C; opb = 32'd7;
      for (int k = 0; k < 100; k++) begin
         if (done === 1'b1) begin lat1 = k; break; end
         @(posedge clk); #1;
      end
      $display("b2b first: hi=%h lo=%h lat=%0d", hi, lo, lat1);
      n_checks++;
      if (lat1 != 33 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFF70) begin
         n_fail++; $display("FAIL b2b_first: lat=%0d hi=%h lo=%h, required 33/FFFFFFFF/FFFFFF70", lat1, hi, lo);
      end
      ref_model(2'd2, 32'hFFFFFF9C, 32'd7, rh, rl, rz);
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 100; k++) begin
         if (done === 1'b1) begin lat2 = k; break; end
         @(posedge clk); #1;
      end
      $display("b2b second: hi=%h lo=%h lat=%0d", hi, lo, lat2);
      n_checks++;
      if (lat2 != 33 || hi !== rh || lo !== rl || div_zero !== rz) begin
         n_fail++; $display("FAIL b2b_second: lat=%0d hi=%h lo=%h, required 33/%h/%h", lat2, hi, lo, rh, rl);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_ignored();
      test_abort_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
